johnson_seq_core: RTL and testbench

//  Parametrised Johnson-sequence generator core, the successor to the fixed 8-bit Johnson counter.

---
 rtl/johnson_seq_core_pkg.sv | 48 ++++
 rtl/johnson_seq_core_if.sv | 33 +++
 rtl/johnson_seq_core_prescaler.sv | 39 +++
 rtl/johnson_seq_core.sv | 103 ++++++++++
 tb/tb_johnson_seq_core.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_seq_core_pkg.sv
// Shared types and helpers for the Johnson-sequence core: direction encodings,
// phase-width calculation, legality check and phase decode.
package johnson_pkg;

  localparam int   JOHNSON_MAX_W = 64;
  localparam logic DIR_FWD       = 1'b1;
  localparam logic DIR_REV       = 1'b0;

  function automatic int phase_w_calc(input int width);
    return $clog2(2 * width);
  endfunction

  // Legal Johnson states have at most one 0/1 boundary between adjacent bits.
  function automatic logic is_johnson_legal(input logic [JOHNSON_MAX_W-1:0] q,
                                            input int                       width);
    int edges;
    edges = 0;
    for (int i = 1; i < JOHNSON_MAX_W; i++) begin
      if ((i < width) && (q[i] != q[i-1])) begin
        edges = edges + 1;
      end else begin
        edges = edges;
      end
    end
    return (edges <= 1);
  endfunction

  function automatic int johnson_phase(input logic [JOHNSON_MAX_W-1:0] q,
                                       input int                       width);
    int ones;
    ones = 0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width) begin
        ones = ones + int'(q[i]);
      end else begin
        ones = ones;
      end
    end
    if (!is_johnson_legal(q, width)) begin
      return 0;
    end else if (q[0] || (ones == 0)) begin
      return ones;
    end else begin
      return (2 * width) - ones;
    end
  endfunction

endpackage

// File: rtl/johnson_seq_core_if.sv
// Control/status bundle of the Johnson-sequence core; the core takes the slave side.
interface johnson_seq_core_if
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) ();

  localparam int PHASE_W = phase_w_calc(WIDTH);

  logic               ena;
  logic               run;
  logic               dir;
  logic [PRESC_W-1:0] div;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   q;
  logic [PHASE_W-1:0] phase;
  logic               tick;
  logic               wrap;
  logic               illegal;

  modport master (
    output ena, run, dir, div, load, load_val,
    input  q, phase, tick, wrap, illegal
  );

  modport slave (
    input  ena, run, dir, div, load, load_val,
    output q, phase, tick, wrap, illegal
  );

endinterface

// File: rtl/johnson_seq_core_prescaler.sv
// Prescaler for the Johnson core: counts enabled running cycles and strobes
// o_advance every div+1 of them; a load restarts the count.
module johnson_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ena,
  input  logic               i_run,
  input  logic               i_load,
  input  logic [PRESC_W-1:0] i_div,
  output logic               o_advance
);

  logic [PRESC_W-1:0] r_pc;
  logic               w_hit;

  // Using >= lets a div lowered below the running count fire on the next cycle.
  always_comb begin
    w_hit     = (r_pc >= i_div);
    o_advance = i_ena & i_run & w_hit;
  end

  // Count register; holds while paused or disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= {PRESC_W{1'b0}};
    end else if (i_ena && i_load) begin
      r_pc <= {PRESC_W{1'b0}};
    end else if (o_advance) begin
      r_pc <= {PRESC_W{1'b0}};
    end else if (i_ena && i_run) begin
      r_pc <= r_pc + PRESC_W'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

endmodule

// File: rtl/johnson_seq_core.sv
// Parametrised Johnson-sequence generator. Define JOHNSON_SELFCORRECT_EN to make
// an advance from an illegal state return the register to all-zeros.
module johnson_seq_core
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  johnson_seq_core_if.slave bus
);

  localparam int PHASE_W    = phase_w_calc(WIDTH);
  localparam int LAST_PHASE = (2 * WIDTH) - 1;

  logic [WIDTH-1:0]         r_q;
  logic                     r_tick;
  logic                     r_wrap;
  logic [WIDTH-1:0]         w_q_step;
  logic [WIDTH-1:0]         w_q_next;
  logic                     w_tick_next;
  logic                     w_wrap_next;
  logic                     w_wrap_cond;
  logic                     w_advance;
  logic                     w_legal;
  logic [JOHNSON_MAX_W-1:0] w_q_ext;
  int                       w_phase_int;

  johnson_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ena     (bus.ena),
    .i_run     (bus.run),
    .i_load    (bus.load),
    .i_div     (bus.div),
    .o_advance (w_advance)
  );

  // Decode legality and phase from the current register value.
  always_comb begin
    w_q_ext              = {JOHNSON_MAX_W{1'b0}};
    w_q_ext[WIDTH-1:0]   = r_q;
    w_legal              = is_johnson_legal(w_q_ext, WIDTH);
    w_phase_int          = johnson_phase(w_q_ext, WIDTH);
  end

  // Next register value and pulse flags; a load always wins over an advance.
  always_comb begin
    w_q_next    = r_q;
    w_tick_next = 1'b0;
    w_wrap_next = 1'b0;
    if (bus.dir == DIR_FWD) begin
      w_q_step = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
    end else begin
      w_q_step = {~r_q[0], r_q[WIDTH-1:1]};
    end
    w_wrap_cond = w_legal &&
                  (((bus.dir == DIR_FWD) && (w_phase_int == LAST_PHASE)) ||
                   ((bus.dir == DIR_REV) && (w_phase_int == 0)));
    if (!bus.ena) begin
      w_q_next = r_q;
    end else if (bus.load) begin
      w_q_next = bus.load_val;
    end else if (w_advance) begin
      w_tick_next = 1'b1;
`ifdef JOHNSON_SELFCORRECT_EN
      if (!w_legal) begin
        w_q_next    = {WIDTH{1'b0}};
        w_wrap_next = 1'b0;
      end else begin
        w_q_next    = w_q_step;
        w_wrap_next = w_wrap_cond;
      end
`else
      w_q_next    = w_q_step;
      w_wrap_next = w_wrap_cond;
`endif
    end else begin
      w_q_next = r_q;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= {WIDTH{1'b0}};
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_tick <= w_tick_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q       = r_q;
  assign bus.phase   = w_phase_int[PHASE_W-1:0];
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;
  assign bus.illegal = ~w_legal;

endmodule

// File: tb/tb_johnson_seq_core.sv
// Scoreboard bench for johnson_seq_core (WIDTH=4 main instance, WIDTH=7 wrap run);
// honours JOHNSON_SELFCORRECT_EN for the illegal-state case.
module tb_johnson_seq_core;

  typedef struct {
    int q;
    int phase;
    int wrap;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   t7       = 0;
  int   w7       = 0;
  int   base;
  exp_t exp_q[$];
  exp_t mon_e;
  int   seq1[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
  int   ph1[8]  = '{1, 2, 3, 4, 5, 6, 7, 0};

  johnson_seq_core_if #(.WIDTH(4), .PRESC_W(8)) bus4 ();
  johnson_seq_core_if #(.WIDTH(7), .PRESC_W(8)) bus7 ();

  johnson_seq_core #(.WIDTH(4), .PRESC_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  johnson_seq_core #(.WIDTH(7), .PRESC_W(8)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_tick(input int q, input int ph, input int wr, input int at);
    exp_t e;
    e.q     = q;
    e.phase = ph;
    e.wrap  = wr;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every tick of the 4-bit instance must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_tick: none by cycle %0d, expected at cycle %0d q=%0d", cyc, mon_e.cyc, mon_e.q);
      end
      if (bus4.tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tick: tick at cycle %0d with q=%0d, expected no tick", cyc, bus4.q);
        end else begin
          mon_e = exp_q.pop_front();
          check("tick_cycle", cyc, mon_e.cyc);
          check("tick_q", int'(bus4.q), mon_e.q);
          check("tick_phase", int'(bus4.phase), mon_e.phase);
          check("tick_wrap", int'(bus4.wrap), mon_e.wrap);
        end
      end else if (bus4.wrap === 1'b1) begin
        n_checks++;
        n_errors++;
        $display("FAIL wrap_without_tick: wrap=1 tick=0 at cycle %0d, expected wrap=0", cyc);
      end
    end
  end

  always @(negedge clk) begin
    if ((rst_n === 1'b1) && (bus7.tick === 1'b1)) t7++;
    if ((rst_n === 1'b1) && (bus7.wrap === 1'b1)) w7++;
  end

  initial begin
    rst_n         = 1'b1;
    bus4.ena      = 1'b0; bus4.run = 1'b0; bus4.dir = 1'b1; bus4.div = 8'd0;
    bus4.load     = 1'b0; bus4.load_val = 4'd0;
    bus7.ena      = 1'b0; bus7.run = 1'b0; bus7.dir = 1'b1; bus7.div = 8'd0;
    bus7.load     = 1'b0; bus7.load_val = 7'd0;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("reset_q", int'(bus4.q), 0);
    check("reset_phase", int'(bus4.phase), 0);
    check("reset_illegal", int'(bus4.illegal), 0);
    check("reset_tick", int'(bus4.tick), 0);
    check("reset_wrap", int'(bus4.wrap), 0);

    // Forward run at div=0: one advance per cycle, wrap only into 0000.
    bus4.ena = 1'b1; bus4.run = 1'b1; bus4.dir = 1'b1; bus4.div = 8'd0;
    base = cyc;
    for (int k = 0; k < 8; k++) expect_tick(seq1[k], ph1[k], (k == 7) ? 1 : 0, base + k + 1);
    step(8);
    bus4.run = 1'b0;

    // div=2 with a 5-cycle pause at pc=1.
    bus4.div = 8'd2; bus4.run = 1'b1;
    base = cyc;
    expect_tick(1, 1, 0, base + 3);
    step(4);
    bus4.run = 1'b0;
    step(3);
    check("pause_q_held", int'(bus4.q), 1);
    step(2);
    bus4.run = 1'b1;
    base = cyc;
    expect_tick(3, 2, 0, base + 2);
    expect_tick(7, 3, 0, base + 5);
    expect_tick(15, 4, 0, base + 8);
    step(8);
    bus4.run = 1'b0;

    // Load on the cycle an advance would fire; count restarts.
    bus4.run = 1'b1;
    step(2);
    bus4.load = 1'b1; bus4.load_val = 4'b0111;
    step(1);
    bus4.load = 1'b0;
    check("load_q", int'(bus4.q), 7);
    check("load_phase", int'(bus4.phase), 3);
    check("load_tick", int'(bus4.tick), 0);
    base = cyc;
    expect_tick(15, 4, 0, base + 3);
    step(3);
    bus4.run = 1'b0;

    // Asynchronous reset between edges while q=1110 and tick=1.
    bus4.div = 8'd0; bus4.run = 1'b1;
    step(1);
    bus4.run = 1'b0;
    check("pre_reset_q", int'(bus4.q), 14);
    check("pre_reset_tick", int'(bus4.tick), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_q", int'(bus4.q), 0);
    check("async_reset_tick", int'(bus4.tick), 0);
    check("async_reset_wrap", int'(bus4.wrap), 0);
    check("async_reset_phase", int'(bus4.phase), 0);

    // Reverse from reset: 0000 -> 1000 wraps, then 1100.
    bus4.dir = 1'b0; bus4.div = 8'd0; bus4.run = 1'b1; bus4.ena = 1'b1;
    step(2);
    rst_n = 1'b1;
    base = cyc;
    expect_tick(8, 7, 1, base + 1);
    expect_tick(12, 6, 0, base + 2);
    step(2);
    bus4.run = 1'b0;

    // Illegal state handling.
    bus4.load = 1'b1; bus4.load_val = 4'b0101;
    step(1);
    bus4.load = 1'b0;
    check("illegal_q", int'(bus4.q), 5);
    check("illegal_flag", int'(bus4.illegal), 1);
    check("illegal_phase", int'(bus4.phase), 0);
    bus4.dir = 1'b1; bus4.run = 1'b1;
    base = cyc;
`ifdef JOHNSON_SELFCORRECT_EN
    expect_tick(0, 0, 0, base + 1);
`else
    expect_tick(11, 0, 0, base + 1);
`endif
    step(1);
    bus4.run = 1'b0;
`ifdef JOHNSON_SELFCORRECT_EN
    check("illegal_after_advance", int'(bus4.illegal), 0);
`else
    check("illegal_after_advance", int'(bus4.illegal), 1);
`endif

    // ena=0 freezes everything and drops the tick.
    bus4.load = 1'b1; bus4.load_val = 4'b0011;
    step(1);
    bus4.load = 1'b0;
    check("legal_load_illegal", int'(bus4.illegal), 0);
    bus4.run = 1'b1;
    base = cyc;
    expect_tick(7, 3, 0, base + 1);
    step(1);
    bus4.ena = 1'b0;
    step(3);
    check("ena0_q_frozen", int'(bus4.q), 7);
    check("ena0_tick", int'(bus4.tick), 0);

    // div lowered below the running count fires on the next cycle.
    bus4.ena = 1'b1; bus4.div = 8'd5;
    step(3);
    bus4.div = 8'd1;
    expect_tick(15, 4, 0, cyc + 1);
    step(1);
    bus4.run = 1'b0;
    step(2);

    // WIDTH=7: 14 advances wrap exactly once.
    bus7.ena = 1'b1; bus7.run = 1'b1; bus7.dir = 1'b1; bus7.div = 8'd0;
    step(7);
    check("w7_mid_q", int'(bus7.q), 127);
    check("w7_mid_phase", int'(bus7.phase), 7);
    step(7);
    bus7.run = 1'b0;
    step(2);
    check("w7_ticks", t7, 14);
    check("w7_wraps", w7, 1);
    check("w7_final_q", int'(bus7.q), 0);
    check("w7_final_phase", int'(bus7.phase), 0);
    check("w7_illegal", int'(bus7.illegal), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
